sudoku_check_seq: RTL



---
 rtl/sudoku_check_seq.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sudoku_check_seq.sv
`timescale 1ns/1ps
// sudoku_check_seq
// Sequences validation of an 81-cell Sudoku board held in a single-read-port
// RAM. On an accepted check pulse it reads every cell of the 27 constraint
// groups (rows 0-8, columns 9-17, boxes 18-26), one read per cycle. Each value
// is evaluated the cycle after its read. The scan stops at the first empty,
// out-of-range or duplicated digit.
//
// Ports:
//   clka       system clock, rising edge
//   restart    asynchronous active-low reset
//   check      start request, sampled only in IDLE
//   rd_en      board RAM read enable
//   rd_addr    board RAM read address (row*9+col), held while rd_en=0
//   rd_data    board RAM data, valid the cycle after rd_en
//   busy       high from the cycle after check is accepted through done
//   done       one-cycle completion pulse
//   solved     verdict, held until the next accepted check
//   err_valid  failure flag, held like solved
//   err_group  failing group index (0-26)
//   err_addr   cell address where the failure was detected
module sudoku_check_seq #(
  parameter int VAL_W  = 4,
  parameter int ADDR_W = 7
) (
  input  logic              clka,
  input  logic              restart,
  input  logic              check,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [VAL_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              solved,
  output logic              err_valid,
  output logic [4:0]        err_group,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

  state_t state_q, state_d;

  // issue stage: tag of the read currently on the RAM port
  logic [4:0]        g_p0;
  logic [3:0]        e_p0;
  // evaluation stage: tag of the read whose data is on rd_data
  logic              vld_p1;
  logic [4:0]        g_p1;
  logic [3:0]        e_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [8:0]        seen_p1;

  logic [4:0]        g_nxt;
  logic [3:0]        e_nxt;
  logic              last_issue;
  logic              start;
  logic              is_digit;
  logic [VAL_W-1:0]  digit_idx;
  logic [8:0]        digit_bit;
  logic [8:0]        seen_eff;
  logic              fail;

  function automatic logic [3:0] div3(input logic [3:0] x);
    logic [3:0] d;
    if (x >= 4'd6)      d = 4'd2;
    else if (x >= 4'd3) d = 4'd1;
    else                d = 4'd0;
    return d;
  endfunction

  function automatic logic [3:0] mod3(input logic [3:0] x);
    logic [3:0] d;
    d = div3(x);
    return x - (d << 1) - d;
  endfunction

  // Cell address of element e of group g, using shift-add only.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] g,
                                                  input logic [3:0] e);
    logic [3:0] row, col, b;
    logic [4:0] gm;
    logic [6:0] r7, c7, sum;
    row = 4'd0;
    col = 4'd0;
    b   = 4'd0;
    gm  = 5'd0;
    if (g < 5'd9) begin
      row = g[3:0];
      col = e;
    end else if (g < 5'd18) begin
      gm  = g - 5'd9;
      row = e;
      col = gm[3:0];
    end else begin
      gm  = g - 5'd18;
      b   = gm[3:0];
      row = (div3(b) << 1) + div3(b) + div3(e);
      col = (mod3(b) << 1) + mod3(b) + mod3(e);
    end
    r7  = {3'b000, row};
    c7  = {3'b000, col};
    sum = (r7 << 3) + r7 + c7;
    return ADDR_W'(sum);
  endfunction

  always_comb begin
    last_issue = (g_p0 == 5'd26) && (e_p0 == 4'd8);
    if (e_p0 == 4'd8) begin
      e_nxt = 4'd0;
      g_nxt = g_p0 + 5'd1;
    end else begin
      e_nxt = e_p0 + 4'd1;
      g_nxt = g_p0;
    end
  end

  // Evaluation: the seen mask restarts at element 0 of every group.
  always_comb begin
    is_digit  = (rd_data != '0) && (rd_data <= VAL_W'(9));
    digit_idx = rd_data - VAL_W'(1);
    digit_bit = is_digit ? (9'd1 << digit_idx) : 9'd0;
    seen_eff  = (e_p1 == 4'd0) ? 9'd0 : seen_p1;
    fail      = vld_p1 && (!is_digit || ((seen_eff & digit_bit) != 9'd0));
  end

  always_ff @(posedge clka or negedge restart) begin
    if (!restart) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == REPORT);
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (check) begin
          start   = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (fail)            state_d = REPORT;
        else if (last_issue) state_d = DRAIN;
      end
      DRAIN:   state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge restart) begin
    if (!restart) begin
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      g_p0      <= '0;
      e_p0      <= '0;
      vld_p1    <= 1'b0;
      g_p1      <= '0;
      e_p1      <= '0;
      addr_p1   <= '0;
      seen_p1   <= '0;
      solved    <= 1'b0;
      err_valid <= 1'b0;
      err_group <= '0;
      err_addr  <= '0;
    end else begin
      // issue -> evaluation boundary; a read issued alongside a failure is dropped
      vld_p1  <= rd_en && !fail;
      g_p1    <= g_p0;
      e_p1    <= e_p0;
      addr_p1 <= rd_addr;
      if (vld_p1 && !fail) seen_p1 <= seen_eff | digit_bit;

      if (start) begin
        rd_en     <= 1'b1;
        rd_addr   <= '0;
        g_p0      <= '0;
        e_p0      <= '0;
        solved    <= 1'b0;
        err_valid <= 1'b0;
        err_group <= '0;
        err_addr  <= '0;
      end else if (state_q == SCAN) begin
        if (fail || last_issue) begin
          rd_en <= 1'b0;
        end else begin
          g_p0    <= g_nxt;
          e_p0    <= e_nxt;
          rd_addr <= cell_addr(g_nxt, e_nxt);
        end
      end

      if (fail) begin
        err_valid <= 1'b1;
        solved    <= 1'b0;
        err_group <= g_p1;
        err_addr  <= addr_p1;
      end else if (state_q == DRAIN) begin
        solved <= 1'b1;
      end
    end
  end

endmodule
